// File: rtl/bus_dev_fifo_if.sv
// Bundle of device-side and arbiter-side signals for one bus_dev_fifo instance.
// Optional BUS_DEV_ADDR_CHECK_EN adds the addr_drop_cnt status signal.
interface bus_dev_fifo_if #(
    parameter int pckg_sz = 16,
    parameter int depth   = 8
);
    localparam int CW = $clog2(depth + 1);

    logic               dev_push;
    logic [pckg_sz-1:0] dev_din;
    logic               dev_full;
    logic               pndng;
    logic               pop;
    logic [pckg_sz-1:0] D_pop;
    logic               push;
    logic [pckg_sz-1:0] D_push;
    logic               dev_pndng;
    logic               dev_pop;
    logic [pckg_sz-1:0] dev_dout;
    logic [CW-1:0]      tx_count;
    logic [CW-1:0]      rx_count;
    logic               tx_ovf;
    logic               rx_ovf;
    logic               udf;
`ifdef BUS_DEV_ADDR_CHECK_EN
    logic [7:0]         addr_drop_cnt;
`endif

    modport slave (
        input  dev_push, dev_din, pop, push, D_push, dev_pop,
        output dev_full, pndng, D_pop, dev_pndng, dev_dout,
        output tx_count, rx_count, tx_ovf, rx_ovf, udf
`ifdef BUS_DEV_ADDR_CHECK_EN
        , output addr_drop_cnt
`endif
    );

    modport master (
        output dev_push, dev_din, pop, push, D_push, dev_pop,
        input  dev_full, pndng, D_pop, dev_pndng, dev_dout,
        input  tx_count, rx_count, tx_ovf, rx_ovf, udf
`ifdef BUS_DEV_ADDR_CHECK_EN
        , input addr_drop_cnt
`endif
    );
endinterface

// File: rtl/bus_dev_fifo.sv
// Per-device TX/RX first-word-fall-through FIFO stage between a bus device and the arbiter.
// Define BUS_DEV_ADDR_CHECK_EN to filter RX packets by destination ID and count the drops.
module bus_dev_fifo_core #(
    parameter int pckg_sz = 16,
    parameter int depth   = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_push,
    input  logic [pckg_sz-1:0]           i_din,
    input  logic                         i_pop,
    output logic [pckg_sz-1:0]           o_dout,
    output logic                         o_pndng,
    output logic                         o_full,
    output logic [$clog2(depth+1)-1:0]   o_count,
    output logic                         o_ovf,
    output logic                         o_udf
);
    localparam int AW = $clog2(depth);
    localparam int CW = $clog2(depth + 1);

    logic [pckg_sz-1:0] r_mem [depth];
    logic [AW-1:0]      r_rd_ptr;
    logic [AW-1:0]      r_wr_ptr;
    logic [CW-1:0]      r_count;
    logic               r_ovf;
    logic               r_udf;

    logic w_full;
    logic w_empty;
    logic w_do_push;
    logic w_do_pop;

    assign w_full  = (r_count == CW'(depth));
    assign w_empty = (r_count == '0);

    // A pop at full frees the slot the same-cycle push needs; a pop at empty never bypasses.
    assign w_do_push = i_push && (!w_full || i_pop);
    assign w_do_pop  = i_pop && !w_empty;

    always_ff @(posedge clk) begin
        if (!reset && w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (i_push && w_full && !i_pop) begin
                r_ovf <= 1'b1;
            end
            if (i_pop && w_empty) begin
                r_udf <= 1'b1;
            end
        end
    end

    assign o_dout  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_pndng = !w_empty;
    assign o_full  = w_full;
    assign o_count = r_count;
    assign o_ovf   = r_ovf;
    assign o_udf   = r_udf;
endmodule

module bus_dev_fifo #(
    parameter int         pckg_sz   = 16,
    parameter int         depth     = 8,
    parameter logic [7:0] drv_id    = 8'd0,
    parameter logic [7:0] broadcast = 8'b0000_0111
) (
    input  logic                clk,
    input  logic                reset,
    bus_dev_fifo_if.slave       bus
);
    logic w_rx_push;
    logic w_tx_udf;
    logic w_rx_udf;

`ifdef BUS_DEV_ADDR_CHECK_EN
    logic [7:0] w_dest;
    logic       w_addr_ok;
    logic [7:0] r_drop_cnt;

    assign w_dest    = bus.D_push[pckg_sz-1 -: 8];
    assign w_addr_ok = (w_dest == drv_id) || (w_dest == broadcast);
    assign w_rx_push = bus.push && w_addr_ok;

    // Filtered packets never reach the RX FIFO, so they cannot raise rx_ovf.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_drop_cnt <= '0;
        end else if (bus.push && !w_addr_ok && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    assign bus.addr_drop_cnt = r_drop_cnt;
`else
    logic w_unused_cfg;

    assign w_unused_cfg = ^{drv_id, broadcast};
    assign w_rx_push    = bus.push;
`endif

    bus_dev_fifo_core #(
        .pckg_sz (pckg_sz),
        .depth   (depth)
    ) u_tx (
        .clk     (clk),
        .reset   (reset),
        .i_push  (bus.dev_push),
        .i_din   (bus.dev_din),
        .i_pop   (bus.pop),
        .o_dout  (bus.D_pop),
        .o_pndng (bus.pndng),
        .o_full  (bus.dev_full),
        .o_count (bus.tx_count),
        .o_ovf   (bus.tx_ovf),
        .o_udf   (w_tx_udf)
    );

    logic w_rx_full_unused;

    bus_dev_fifo_core #(
        .pckg_sz (pckg_sz),
        .depth   (depth)
    ) u_rx (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_rx_push),
        .i_din   (bus.D_push),
        .i_pop   (bus.dev_pop),
        .o_dout  (bus.dev_dout),
        .o_pndng (bus.dev_pndng),
        .o_full  (w_rx_full_unused),
        .o_count (bus.rx_count),
        .o_ovf   (bus.rx_ovf),
        .o_udf   (w_rx_udf)
    );

    assign bus.udf = w_tx_udf | w_rx_udf;
endmodule

// File: tb/tb_bus_dev_fifo.sv
// Directed self-checking bench for bus_dev_fifo (depth 8, 16-bit packets, drv_id 2).
// Build with BUS_DEV_ADDR_CHECK_EN to also exercise the RX destination filter.
module tb_bus_dev_fifo;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    bus_dev_fifo_if #(.pckg_sz(16), .depth(8)) bus ();

    bus_dev_fifo #(
        .pckg_sz   (16),
        .depth     (8),
        .drv_id    (8'd2),
        .broadcast (8'b0000_0111)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.dev_push = 1'b0;
        bus.dev_din  = '0;
        bus.pop      = 1'b0;
        bus.push     = 1'b0;
        bus.D_push   = '0;
        bus.dev_pop  = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({bus.pndng, bus.dev_pndng, bus.dev_full, bus.tx_ovf, bus.rx_ovf, bus.udf} !== 6'b0) begin
            failures++;
            $display("[TB] FAIL reset_flags got=%b exp=000000",
                     {bus.pndng, bus.dev_pndng, bus.dev_full, bus.tx_ovf, bus.rx_ovf, bus.udf});
        end
        checks++;
        if (bus.tx_count !== 4'd0 || bus.rx_count !== 4'd0) begin
            failures++;
            $display("[TB] FAIL reset_counts got tx=%0d rx=%0d exp=0/0", bus.tx_count, bus.rx_count);
        end
        checks++;
        if (bus.D_pop !== 16'h0000 || bus.dev_dout !== 16'h0000) begin
            failures++;
            $display("[TB] FAIL reset_data got D_pop=%h dev_dout=%h exp=0000", bus.D_pop, bus.dev_dout);
        end
    endtask

    task automatic test_tx_fill_drain();
        bus.dev_push = 1'b1;
        bus.dev_din  = 16'h0101;
        step();
        checks++;
        if (bus.pndng !== 1'b1 || bus.D_pop !== 16'h0101) begin
            failures++;
            $display("[TB] FAIL first_word got pndng=%b D_pop=%h exp=1/0101", bus.pndng, bus.D_pop);
        end
        for (int i = 1; i < 8; i++) begin
            bus.dev_din = 16'(16'h0101 + i);
            step();
        end
        checks++;
        if (bus.dev_full !== 1'b1 || bus.tx_count !== 4'd8 || bus.tx_ovf !== 1'b0) begin
            failures++;
            $display("[TB] FAIL tx_full got full=%b count=%0d ovf=%b exp=1/8/0",
                     bus.dev_full, bus.tx_count, bus.tx_ovf);
        end
        bus.dev_din = 16'h0109;
        step();
        bus.dev_push = 1'b0;
        checks++;
        if (bus.tx_ovf !== 1'b1 || bus.tx_count !== 4'd8 || bus.D_pop !== 16'h0101) begin
            failures++;
            $display("[TB] FAIL tx_overflow got ovf=%b count=%0d D_pop=%h exp=1/8/0101",
                     bus.tx_ovf, bus.tx_count, bus.D_pop);
        end
        bus.pop = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (bus.D_pop !== 16'(16'h0101 + i)) begin
                failures++;
                $display("[TB] FAIL drain_order[%0d] got=%h exp=%h", i, bus.D_pop, 16'(16'h0101 + i));
            end
            step();
        end
        bus.pop = 1'b0;
        checks++;
        if (bus.pndng !== 1'b0 || bus.tx_count !== 4'd0 || bus.D_pop !== 16'h0000 || bus.udf !== 1'b0) begin
            failures++;
            $display("[TB] FAIL drain_empty got pndng=%b count=%0d D_pop=%h udf=%b exp=0/0/0000/0",
                     bus.pndng, bus.tx_count, bus.D_pop, bus.udf);
        end
    endtask

    task automatic test_wrap();
        bus.dev_push = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.dev_din = 16'(16'h1000 + i);
            step();
        end
        bus.dev_push = 1'b0;
        bus.pop      = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
        end
        bus.pop      = 1'b0;
        bus.dev_push = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.dev_din = 16'(16'h2000 + i);
            step();
        end
        bus.dev_push = 1'b0;
        checks++;
        if (bus.tx_count !== 4'd6) begin
            failures++;
            $display("[TB] FAIL wrap_count got=%0d exp=6", bus.tx_count);
        end
        bus.pop = 1'b1;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (bus.D_pop !== 16'(16'h2000 + i)) begin
                failures++;
                $display("[TB] FAIL wrap_order[%0d] got=%h exp=%h", i, bus.D_pop, 16'(16'h2000 + i));
            end
            step();
        end
        bus.pop = 1'b0;
    endtask

    task automatic test_back_to_back();
        bus.dev_push = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.dev_din = 16'(16'h3001 + i);
            step();
        end
        bus.pop = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.dev_din = 16'(16'h3004 + i);
            checks++;
            if (bus.D_pop !== 16'(16'h3001 + i)) begin
                failures++;
                $display("[TB] FAIL b2b_head[%0d] got=%h exp=%h", i, bus.D_pop, 16'(16'h3001 + i));
            end
            step();
            checks++;
            if (bus.tx_count !== 4'd3) begin
                failures++;
                $display("[TB] FAIL b2b_count[%0d] got=%0d exp=3", i, bus.tx_count);
            end
        end
        bus.dev_push = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.D_pop !== 16'(16'h3006 + i)) begin
                failures++;
                $display("[TB] FAIL b2b_tail[%0d] got=%h exp=%h", i, bus.D_pop, 16'(16'h3006 + i));
            end
            step();
        end
        bus.pop = 1'b0;
    endtask

    task automatic test_full_boundary();
        apply_reset();
        bus.dev_push = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.dev_din = 16'(16'h4001 + i);
            step();
        end
        bus.dev_din = 16'hAAAA;
        bus.pop     = 1'b1;
        step();
        bus.dev_push = 1'b0;
        checks++;
        if (bus.tx_count !== 4'd8 || bus.tx_ovf !== 1'b0 || bus.D_pop !== 16'h4002) begin
            failures++;
            $display("[TB] FAIL full_push_pop got count=%0d ovf=%b D_pop=%h exp=8/0/4002",
                     bus.tx_count, bus.tx_ovf, bus.D_pop);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (bus.D_pop !== ((i == 7) ? 16'hAAAA : 16'(16'h4002 + i))) begin
                failures++;
                $display("[TB] FAIL full_drain[%0d] got=%h exp=%h", i, bus.D_pop,
                         (i == 7) ? 16'hAAAA : 16'(16'h4002 + i));
            end
            step();
        end
        bus.pop = 1'b0;
        checks++;
        if (bus.pndng !== 1'b0 || bus.udf !== 1'b0) begin
            failures++;
            $display("[TB] FAIL full_drain_end got pndng=%b udf=%b exp=0/0", bus.pndng, bus.udf);
        end
    endtask

    task automatic test_empty_pop();
        apply_reset();
        bus.dev_pop = 1'b1;
        step();
        checks++;
        if (bus.udf !== 1'b1 || bus.rx_count !== 4'd0 || bus.dev_pndng !== 1'b0) begin
            failures++;
            $display("[TB] FAIL empty_pop got udf=%b rx_count=%0d dev_pndng=%b exp=1/0/0",
                     bus.udf, bus.rx_count, bus.dev_pndng);
        end
        bus.push   = 1'b1;
        bus.D_push = 16'h0203;
        step();
        bus.dev_pop = 1'b0;
        checks++;
        if (bus.rx_count !== 4'd1 || bus.dev_dout !== 16'h0203 || bus.dev_pndng !== 1'b1) begin
            failures++;
            $display("[TB] FAIL empty_push_pop got rx_count=%0d dev_dout=%h exp=1/0203",
                     bus.rx_count, bus.dev_dout);
        end
        for (int i = 0; i < 7; i++) begin
            bus.D_push = 16'(16'h0204 + i);
            step();
        end
        bus.D_push = 16'h02FF;
        step();
        bus.push = 1'b0;
        checks++;
        if (bus.rx_ovf !== 1'b1 || bus.rx_count !== 4'd8 || bus.dev_dout !== 16'h0203 || bus.tx_ovf !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rx_overflow got rx_ovf=%b rx_count=%0d dev_dout=%h tx_ovf=%b exp=1/8/0203/0",
                     bus.rx_ovf, bus.rx_count, bus.dev_dout, bus.tx_ovf);
        end
        checks++;
        if (bus.tx_count !== 4'd0 || bus.pndng !== 1'b0) begin
            failures++;
            $display("[TB] FAIL side_independence got tx_count=%0d pndng=%b exp=0/0", bus.tx_count, bus.pndng);
        end
    endtask

`ifdef BUS_DEV_ADDR_CHECK_EN
    task automatic test_addr_check();
        apply_reset();
        bus.push   = 1'b1;
        bus.D_push = 16'h0211;
        step();
        bus.D_push = 16'h0711;
        step();
        bus.D_push = 16'h0311;
        step();
        bus.push = 1'b0;
        checks++;
        if (bus.addr_drop_cnt !== 8'd1 || bus.rx_count !== 4'd2 || bus.rx_ovf !== 1'b0) begin
            failures++;
            $display("[TB] FAIL addr_filter got drop=%0d rx_count=%0d rx_ovf=%b exp=1/2/0",
                     bus.addr_drop_cnt, bus.rx_count, bus.rx_ovf);
        end
        bus.dev_pop = 1'b1;
        checks++;
        if (bus.dev_dout !== 16'h0211) begin
            failures++;
            $display("[TB] FAIL addr_head0 got=%h exp=0211", bus.dev_dout);
        end
        step();
        checks++;
        if (bus.dev_dout !== 16'h0711) begin
            failures++;
            $display("[TB] FAIL addr_head1 got=%h exp=0711", bus.dev_dout);
        end
        step();
        bus.dev_pop = 1'b0;
    endtask
`endif

    task automatic test_reset_mid_burst();
        apply_reset();
        bus.dev_push = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.dev_din = 16'(16'h5001 + i);
            step();
        end
        checks++;
        if (bus.tx_count !== 4'd5) begin
            failures++;
            $display("[TB] FAIL mid_pre_count got=%0d exp=5", bus.tx_count);
        end
        bus.dev_din = 16'hDEAD;
        reset       = 1'b1;
        step();
        checks++;
        if (bus.tx_count !== 4'd0 || bus.pndng !== 1'b0 || bus.D_pop !== 16'h0000) begin
            failures++;
            $display("[TB] FAIL mid_reset got count=%0d pndng=%b D_pop=%h exp=0/0/0000",
                     bus.tx_count, bus.pndng, bus.D_pop);
        end
        reset        = 1'b0;
        bus.dev_push = 1'b0;
        step();
        checks++;
        if (bus.tx_count !== 4'd0 || bus.pndng !== 1'b0) begin
            failures++;
            $display("[TB] FAIL mid_after got count=%0d pndng=%b exp=0/0", bus.tx_count, bus.pndng);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        idle_inputs();
        test_reset();
        test_tx_fill_drain();
        test_wrap();
        test_back_to_back();
        test_full_boundary();
        test_empty_pop();
`ifdef BUS_DEV_ADDR_CHECK_EN
        test_addr_check();
`endif
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
